// File: rtl/warmboot_pkg.sv
// Shared types and helpers for the warmboot request controller.
package warmboot_pkg;

  localparam int WB_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  typedef logic [1:0] wb_image_t;

  // An image is selectable when its bit in the mask is set.
  function automatic logic image_allowed(input logic [3:0] mask, input wb_image_t img);
    return mask[img];
  endfunction

endpackage

// File: rtl/warmboot_ctrl_timer.sv
// wb_cycle_timer: loadable 8-bit down-counter with a zero flag.
// Load has priority over decrement; the count holds when neither is asserted.
module wb_cycle_timer
  import warmboot_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WB_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [WB_CNT_W-1:0] count_q;
  logic [WB_CNT_W-1:0] count_d;

  // Next count: reload, step down, or hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - {{(WB_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {WB_CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == {WB_CNT_W{1'b0}});

endmodule

// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: validates a reboot request, holds S1/S0 stable for a setup
// window, then pulses BOOT for a hold window and parks in DONE until reset.
// Optional macro WARMBOOT_PRIM_EN: when defined, an SB_WARMBOOT primitive is
// instantiated and driven from the registered outputs.
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int         SETUP_CYCLES = 16,
  parameter int         HOLD_CYCLES  = 16,
  parameter logic [3:0] IMG_MASK     = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_image,
  output logic       req_ready,
  output logic       busy,
  output logic       err,
  output logic       wb_boot,
  output logic       wb_s1,
  output logic       wb_s0
);

  // Counter reload values: the window ends on the edge where the count is 0.
  localparam logic [WB_CNT_W-1:0] SETUP_LOAD = WB_CNT_W'(SETUP_CYCLES - 1);
  localparam logic [WB_CNT_W-1:0] HOLD_LOAD  = WB_CNT_W'(HOLD_CYCLES - 1);

  wb_state_t           state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                wb_boot_q, wb_boot_d;
  wb_image_t           wb_sel_q, wb_sel_d;

  logic                tmr_load;
  logic [WB_CNT_W-1:0] tmr_load_val;
  logic                tmr_dec;
  logic                tmr_zero;

  wb_cycle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;
    err_d        = 1'b0;
    wb_boot_d    = wb_boot_q;
    wb_sel_d     = wb_sel_q;
    tmr_load     = 1'b0;
    tmr_load_val = {WB_CNT_W{1'b0}};
    tmr_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (image_allowed(IMG_MASK, req_image)) begin
            wb_sel_d     = req_image;
            tmr_load     = 1'b1;
            tmr_load_val = SETUP_LOAD;
            state_d      = SETUP;
            req_ready_d  = 1'b0;
            busy_d       = 1'b1;
          end else begin
            // Rejected image: flag it, keep the select lines untouched.
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          wb_boot_d    = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LOAD;
          state_d      = FIRE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      FIRE: begin
        if (tmr_zero) begin
          wb_boot_d = 1'b0;
          state_d   = DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        // Terminal: the device reconfigures or waits here for reset.
        state_d = DONE;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        wb_boot_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      wb_boot_q   <= 1'b0;
      wb_sel_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      wb_boot_q   <= wb_boot_d;
      wb_sel_q    <= wb_sel_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign wb_boot   = wb_boot_q;
  assign wb_s1     = wb_sel_q[1];
  assign wb_s0     = wb_sel_q[0];

`ifdef WARMBOOT_PRIM_EN
  SB_WARMBOOT u_sb_warmboot (
    .BOOT (wb_boot_q),
    .S1   (wb_sel_q[1]),
    .S0   (wb_sel_q[0])
  );
`else
  // No primitive: the ports are the only consumer of the boot controls.
`endif

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Scoreboard bench for warmboot_ctrl. The reference model tracks only the
// accept edge and accepted image; expected outputs follow by arithmetic.
module tb_warmboot_ctrl;

  localparam int         SETUP = 4;
  localparam int         HOLD  = 3;
  localparam logic [3:0] MASK  = 4'b0111;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_image;
  logic       req_ready, busy, err, wb_boot, wb_s1, wb_s0;

  warmboot_ctrl #(
    .SETUP_CYCLES (SETUP),
    .HOLD_CYCLES  (HOLD),
    .IMG_MASK     (MASK)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_image (req_image),
    .req_ready (req_ready),
    .busy      (busy),
    .err       (err),
    .wb_boot   (wb_boot),
    .wb_s1     (wb_s1),
    .wb_s0     (wb_s0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {req_ready, busy, err, wb_boot, wb_s1, wb_s0} after each edge.
  logic [5:0] exp_q[$];

  // Reference model state.
  logic [3:0] mask_v = MASK;
  bit         m_acc;
  int         m_t;
  logic [1:0] m_s;
  int         e;

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got {rdy,busy,err,boot,s1,s0}=%b expected %b at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {req_ready, busy, err, wb_boot, wb_s1, wb_s0};
  endfunction

  // Monitor: compare DUT outputs just after every active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        chk("cycle", outs(), exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of stimulus and predict the outputs after the next edge.
  task automatic step(input logic v, input logic [1:0] img);
    logic err_n;
    logic boot;
    @(negedge clk);
    req_valid = v;
    req_image = img;
    e++;
    err_n = 1'b0;
    if (v && !m_acc) begin
      if (mask_v[img]) begin
        m_acc = 1'b1;
        m_t   = e;
        m_s   = img;
      end else begin
        err_n = 1'b1;
      end
    end
    boot = m_acc && (e >= m_t + SETUP) && (e < m_t + SETUP + HOLD);
    exp_q.push_back({~m_acc, m_acc, err_n, boot, m_s});
  endtask

  // Apply reset between clock edges and check it takes effect without an edge.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset", outs(), 6'b100000);
    req_valid = 1'b1;
    req_image = 2'd1;
    repeat (2) @(negedge clk);
    chk("held_reset", outs(), 6'b100000);
    rst       = 1'b0;
    req_valid = 1'b0;
    m_acc = 1'b0;
    m_t   = 0;
    m_s   = 2'b00;
    e     = 0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_image = 2'd0;
    m_acc = 1'b0;
    m_t   = 0;
    m_s   = 2'b00;
    e     = 0;
    #3;
    chk("reset_state", outs(), 6'b100000);
    @(negedge clk);
    rst = 1'b0;

    // Idle: nothing should move.
    for (int i = 0; i < 100; i++) step(1'b0, 2'($urandom_range(0, 3)));

    // Masked image 3 twice (one err per cycle), then image 1, then ignored image 0s.
    step(1'b1, 2'd3);
    step(1'b1, 2'd3);
    step(1'b0, 2'd0);
    step(1'b1, 2'd1);
    for (int i = 0; i < 12; i++) step(1'b1, 2'd0);

    // Image 2 full sequence into DONE.
    reset_dut();
    step(1'b1, 2'd2);
    for (int i = 0; i < 10; i++) step(1'b0, 2'($urandom_range(0, 3)));

    // Reset mid-FIRE, then a fresh request.
    reset_dut();
    step(1'b1, 2'd2);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0);
    reset_dut();
    step(1'b1, 2'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'd3);

    // Randomized trials, each started from reset.
    for (int t = 0; t < 30; t++) begin
      reset_dut();
      for (int i = 0; i < 14; i++) begin
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
    end

    // Let the monitor drain the queue, bounded.
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
